// File: rtl/control_smoother.sv
// Conditions seven 16-bit control words: synchronises the frame strobe, captures targets, and
// slews outputs toward them once per tick. Define CTRL_SMOOTH_EN for the filter; otherwise pass-through.
module control_smoother #(
    parameter int SHIFT       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Data_Received,
    input  logic [15:0] i_Data0,
    input  logic [15:0] i_Data1,
    input  logic [15:0] i_Data2,
    input  logic [15:0] i_Data3,
    input  logic [15:0] i_Data4,
    input  logic [15:0] i_Data5,
    input  logic [15:0] i_Data6,
    input  logic        i_Tick,
    output logic [15:0] o_Data0,
    output logic [15:0] o_Data1,
    output logic [15:0] o_Data2,
    output logic [15:0] o_Data3,
    output logic [15:0] o_Data4,
    output logic [15:0] o_Data5,
    output logic [15:0] o_Data6,
    output logic        o_Update,
    output logic        o_Busy
);
    logic [15:0]            din   [7];
    logic [15:0]            out_q [7];
    logic [15:0]            out_d [7];
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   pending_q;
    logic                   pending_d;
    logic                   update_q;
    logic                   update_d;
    logic                   capture;
    logic                   rise;

    assign din[0] = i_Data0;
    assign din[1] = i_Data1;
    assign din[2] = i_Data2;
    assign din[3] = i_Data3;
    assign din[4] = i_Data4;
    assign din[5] = i_Data5;
    assign din[6] = i_Data6;

    assign o_Data0  = out_q[0];
    assign o_Data1  = out_q[1];
    assign o_Data2  = out_q[2];
    assign o_Data3  = out_q[3];
    assign o_Data4  = out_q[4];
    assign o_Data5  = out_q[5];
    assign o_Data6  = out_q[6];
    assign o_Update = update_q;

    // A new edge wins over a same-cycle capture so it is never lost.
    assign rise      = sync_q[SYNC_STAGES-1] & ~edge_q;
    assign pending_d = rise | (pending_q & ~capture);

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            sync_q    <= '0;
            edge_q    <= 1'b0;
            pending_q <= 1'b0;
            update_q  <= 1'b0;
            for (int i = 0; i < 7; i++) out_q[i] <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], i_Data_Received};
            edge_q    <= sync_q[SYNC_STAGES-1];
            pending_q <= pending_d;
            update_q  <= update_d;
            out_q     <= out_d;
        end
    end

`ifdef CTRL_SMOOTH_EN
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CALC  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [2:0]         chan_q;
    logic [2:0]         chan_d;
    logic [15:0]        step_q;
    logic [15:0]        step_d;
    logic [15:0]        target_q [7];
    logic [15:0]        target_d [7];
    logic               primed_q;
    logic               primed_d;
    logic signed [16:0] diff;
    logic signed [16:0] floor_step;

    // |step| never exceeds |diff|, so keeping 16 bits and adding modulo 2^16 is exact.
    assign diff       = $signed({1'b0, target_q[chan_q]}) - $signed({1'b0, out_q[chan_q]});
    assign floor_step = diff >>> SHIFT;
    assign o_Busy     = (state_q != ST_IDLE);

    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        step_d   = step_q;
        target_d = target_q;
        out_d    = out_q;
        primed_d = primed_q;
        update_d = 1'b0;
        capture  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    capture  = 1'b1;
                    target_d = din;
                    if (!primed_q) begin
                        out_d    = din;
                        primed_d = 1'b1;
                        update_d = 1'b1;
                    end
                end else if (i_Tick && primed_q) begin
                    chan_d  = 3'd0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                // Small positive differences still creep up by one so the output lands exactly.
                if (diff != 17'sd0 && floor_step == 17'sd0) step_d = 16'd1;
                else                                        step_d = floor_step[15:0];
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                out_d[chan_q] = out_q[chan_q] + step_q;
                if (chan_q == 3'd6) begin
                    state_d = ST_DONE;
                end else begin
                    chan_d  = chan_q + 3'd1;
                    state_d = ST_CALC;
                end
            end
            default: begin
                update_d = 1'b1;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q  <= ST_IDLE;
            chan_q   <= '0;
            step_q   <= '0;
            primed_q <= 1'b0;
            for (int i = 0; i < 7; i++) target_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            chan_q   <= chan_d;
            step_q   <= step_d;
            primed_q <= primed_d;
            target_q <= target_d;
        end
    end
`else
    logic unused_cfg;

    always_comb begin
        capture  = pending_q;
        update_d = pending_q;
        out_d    = out_q;
        if (pending_q) out_d = din;
    end

    assign o_Busy     = 1'b0;
    assign unused_cfg = i_Tick ^ (SHIFT > 0);
`endif
endmodule

// File: tb/tb_control_smoother.sv
// Randomised bench for control_smoother with a floor-division reference model of the slew filter.
// Works for both builds; the CTRL_SMOOTH_EN define selects the expected behaviour.
module tb_control_smoother;
    localparam int SHIFT       = 4;
    localparam int SYNC_STAGES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        strobe;
    logic        tick;
    logic [15:0] stim [7];
    logic [15:0] obs  [7];
    logic        o_update;
    logic        o_busy;

    int          m_out [7];
    int          m_tgt [7];
    bit          m_primed;
    int          tests_run    = 0;
    int          tests_failed = 0;

    always #5 clk = ~clk;

    control_smoother #(.SHIFT(SHIFT), .SYNC_STAGES(SYNC_STAGES)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Data_Received(strobe),
        .i_Data0(stim[0]), .i_Data1(stim[1]), .i_Data2(stim[2]), .i_Data3(stim[3]),
        .i_Data4(stim[4]), .i_Data5(stim[5]), .i_Data6(stim[6]),
        .i_Tick(tick),
        .o_Data0(obs[0]), .o_Data1(obs[1]), .o_Data2(obs[2]), .o_Data3(obs[3]),
        .o_Data4(obs[4]), .o_Data5(obs[5]), .o_Data6(obs[6]),
        .o_Update(o_update), .o_Busy(o_busy)
    );

    task automatic check_val(input string tag, input int got, input int want);
        tests_run++;
        if (got != want) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int i = 0; i < 7; i++) check_val($sformatf("%s_ch%0d", tag, i), int'(obs[i]), m_out[i]);
    endtask

    function automatic int smooth_step(input int d);
        int q;
        int s;
        q = 1 << SHIFT;
        if (d >= 0) s = d / q;
        else        s = -((-d + q - 1) / q);
        if (d != 0 && s == 0) s = 1;
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 7; i++) begin
            m_out[i] = 0;
            m_tgt[i] = 0;
        end
        m_primed = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("reset");
        check_val("reset_update", int'(o_update), 0);
        check_val("reset_busy", int'(o_busy), 0);
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] reset applied and released");
    endtask

    task automatic do_strobe();
        int n_upd;
        int k_first;
        int exp_upd;
        n_upd   = 0;
        k_first = 0;
        @(negedge clk);
        strobe = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 3) strobe = 1'b0;
            if (o_update) begin
                n_upd++;
                if (k_first == 0) k_first = k;
            end
        end
`ifdef CTRL_SMOOTH_EN
        exp_upd = m_primed ? 0 : 1;
`else
        exp_upd = 1;
`endif
        check_val("strobe_update_count", n_upd, exp_upd);
        if (exp_upd == 1) begin
            check_val("strobe_latency", k_first, SYNC_STAGES + 2);
            for (int i = 0; i < 7; i++) m_out[i] = int'(stim[i]);
            m_primed = 1'b1;
        end
        for (int i = 0; i < 7; i++) m_tgt[i] = int'(stim[i]);
        check_outputs("strobe");
        $display("[TB] strobe d0=%0d d5=%0d updates=%0d out0=%0d", stim[0], stim[5], n_upd, obs[0]);
    endtask

    // collide: 0 plain tick, 1 extra tick mid-sweep, 2 strobe mid-sweep, 3 reset mid-sweep
    task automatic do_tick(input int collide);
        int n_upd;
        int k_first;
        int busy_cnt;
        int exp_upd;
        bit primed_start;
        bit was_reset;
        n_upd        = 0;
        k_first      = 0;
        busy_cnt     = 0;
        was_reset    = 1'b0;
        primed_start = m_primed;
        @(negedge clk);
        tick = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            tick = (collide == 1 && k == 5);
            if (collide == 2 && k == 3) strobe = 1'b1;
            if (collide == 2 && k == 6) strobe = 1'b0;
            if (collide == 3 && k == 7) begin
                rst = 1'b1;
                #1;
                model_reset();
                check_outputs("midreset");
                check_val("midreset_busy", int'(o_busy), 0);
                was_reset = 1'b1;
            end
            if (collide == 3 && k == 9) rst = 1'b0;
            if (o_update) begin
                n_upd++;
                if (k_first == 0) k_first = k;
            end
            if (o_busy) busy_cnt++;
        end
`ifdef CTRL_SMOOTH_EN
        exp_upd = (primed_start && !was_reset) ? 1 : 0;
`else
        exp_upd = 0;
`endif
        check_val("tick_update_count", n_upd, exp_upd);
        if (!was_reset) check_val("tick_busy_cycles", busy_cnt, exp_upd * 15);
        if (exp_upd == 1) begin
            check_val("tick_latency", k_first, 16);
            for (int i = 0; i < 7; i++) m_out[i] = m_out[i] + smooth_step(m_tgt[i] - m_out[i]);
            if (collide == 2) for (int i = 0; i < 7; i++) m_tgt[i] = int'(stim[i]);
        end
        check_outputs("tick");
        $display("[TB] tick collide=%0d updates=%0d busy=%0d out0=%0d", collide, n_upd, busy_cnt, obs[0]);
    endtask

    task automatic random_stim(input bit near);
        int v;
        for (int i = 0; i < 7; i++) begin
            if (near) begin
                v = m_out[i] + int'($urandom_range(0, 60)) - 30;
                if (v < 0) v = 0;
                if (v > 65535) v = 65535;
                stim[i] = 16'(v);
            end else begin
                stim[i] = 16'($urandom_range(0, 65535));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        strobe = 1'b0;
        tick   = 1'b0;
        for (int i = 0; i < 7; i++) stim[i] = '0;
        model_reset();
        do_reset();
`ifdef CTRL_SMOOTH_EN
        do_tick(0);
        random_stim(1'b0);
        stim[0] = 16'd1000;
        do_strobe();
        check_val("prime_d0", int'(obs[0]), 1000);
        stim[0] = 16'd2600;
        do_strobe();
        do_tick(0);
        check_val("upward_d0", int'(obs[0]), 1100);

        do_reset();
        stim[0] = 16'd1000;
        do_strobe();
        stim[0] = 16'd0;
        do_strobe();
        do_tick(0);
        check_val("downward_d0", int'(obs[0]), 937);

        do_reset();
        stim[0] = 16'd1000;
        do_strobe();
        stim[0] = 16'd1005;
        do_strobe();
        repeat (6) do_tick(0);
        check_val("converge_d0", int'(obs[0]), 1005);

        do_tick(1);
        random_stim(1'b0);
        do_tick(2);
        do_tick(0);
        do_tick(3);
        random_stim(1'b0);
        do_strobe();
`else
        do_tick(0);
        stim[5] = 16'h1234;
        do_strobe();
        check_val("passthru_d5", int'(obs[5]), 16'h1234);
        do_tick(0);
        do_reset();
`endif
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                random_stim(1'($urandom_range(0, 1)));
                do_strobe();
            end else begin
                do_tick(0);
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
